// File: rtl/data_mem_port.sv
// Load/store front end for a word-organised data RAM: byte/half/word requests,
// read-modify-write for sub-word stores, lane-extracted sign/zero-extended loads.
module data_mem_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ram_re,
  input  logic [31:0] ram_rd,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  output logic [29:0] ram_addr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        we_reg, uns_reg, err_reg;
  logic [1:0]  size_reg, lane_reg;
  logic [15:0] sub_data_reg;
  logic [29:0] addr_reg;
  logic [31:0] rdata_reg, wd_reg;

  logic        req_err;
  logic [31:0] ins_data, merged, load_val, byte_shift;
  logic [3:0]  lane_sel;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) begin
        if (req_err)                          state_next = RESP;
        else if (req_we && req_size == 2'b10) state_next = WRITE;
        else                                  state_next = READ;
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      READ:    ram_re    = 1'b1;
      WRITE:   ram_we    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Store data replicated across lanes so each lane only needs a select, not a shift.
  assign ins_data = (size_reg == 2'b00) ? {4{sub_data_reg[7:0]}} : {2{sub_data_reg}};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_sel[gi] = (size_reg == 2'b00) ? (lane_reg == 2'(gi))
                                                : (lane_reg[1] == 1'(gi / 2));
      assign merged[gi*8 +: 8] = lane_sel[gi] ? ins_data[gi*8 +: 8] : ram_rd[gi*8 +: 8];
    end
  endgenerate

  assign byte_shift = ram_rd >> {lane_reg, 3'b000};
  assign byte_val   = byte_shift[7:0];
  assign half_val   = lane_reg[1] ? ram_rd[31:16] : ram_rd[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_val = {{24{~uns_reg & byte_val[7]}}, byte_val};
      2'b01:   load_val = {{16{~uns_reg & half_val[15]}}, half_val};
      default: load_val = ram_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg       <= 1'b0;
      uns_reg      <= 1'b0;
      err_reg      <= 1'b0;
      size_reg     <= 2'b00;
      lane_reg     <= 2'b00;
      sub_data_reg <= 16'h0;
      addr_reg     <= 30'h0;
      rdata_reg    <= 32'h0;
      wd_reg       <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          we_reg       <= req_we;
          uns_reg      <= req_unsigned;
          size_reg     <= req_size;
          lane_reg     <= req_addr[1:0];
          addr_reg     <= req_addr[31:2];
          sub_data_reg <= req_wdata[15:0];
          wd_reg       <= req_wdata;
          rdata_reg    <= 32'h0;
          err_reg      <= req_err;
        end
        READ: begin
          if (we_reg) wd_reg    <= merged;
          else        rdata_reg <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign ram_addr  = addr_reg;
  assign ram_wd    = wd_reg;
endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: directed vector table, back-pressure and reset corner
// cases, then random traffic checked against a byte-addressed memory model.
module tb_data_mem_port;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, ram_re, ram_we;
  logic [31:0] rsp_rdata, ram_rd, ram_wd;
  logic [29:0] ram_addr;

  int          n_cmp = 0, n_bad = 0;
  logic        init_mem = 1'b1;
  logic [31:0] mem [0:63];
  logic [7:0]  ref_b [0:255];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_word;
  } vec_t;

  data_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_re(ram_re), .ram_rd(ram_rd),
    .ram_we(ram_we), .ram_wd(ram_wd), .ram_addr(ram_addr)
  );

  always #5 clk = ~clk;

  // RAM model: whole-word writes, read data valid while re is high.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int w = 0; w < 64; w++)
        mem[w] <= {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    end else if (ram_we) begin
      mem[ram_addr[5:0]] <= ram_wd;
    end
  end
  assign ram_rd = ram_re ? mem[ram_addr[5:0]] : 32'hxxxxxxxx;

  always @(negedge clk) begin
    if (rst_n && (ram_re || ram_we)) begin
      n_cmp++;
      if ((ram_re && ram_we) || ram_addr[29:6] != 24'h0) begin
        n_bad++;
        $display("FAIL ram_pins: re=%b we=%b addr=%h", ram_re, ram_we, ram_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory.
  function automatic void ref_op(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
    int n;
    logic [31:0] v;
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err   = (size == 2'd3) || (int'(addr) % n != 0);
    rdata = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_b[int'(addr) + i] = wdata[8*i +: 8];
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = n - 1; i >= 0; i--) v = (v << 8) | {24'h0, ref_b[int'(addr) + i]};
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      rdata = v;
      lat   = 2;
    end
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int n_re, output int n_we);
    chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the block must have latched them.
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wdata;
    lat = 1; n_re = 0; n_we = 0;
    while (!rsp_valid && lat < 10) begin
      n_re += int'(ram_re);
      n_we += int'(ram_we);
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: rsp_valid still 0 after %0d cycles", lat);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
  endtask

  vec_t        vt [14];
  logic [31:0] r, er, old_word;
  logic        e, ee;
  int          l, el, nr, nw;
  logic        t_we, t_uns;
  logic [1:0]  t_size;
  logic [7:0]  t_addr;
  logic [31:0] t_wd;

  initial begin
    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2, 0, 1, 32'h11223344};
    vt[3]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h123456A5, 32'h0,        1'b0, 3, 1, 1, 32'h1122A544};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 1, 0, 32'h1122A544};
    vt[5]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h000000A5, 1'b0, 2, 1, 0, 32'h1122A544};
    vt[6]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h55558001, 32'h0,        1'b0, 3, 1, 1, 32'h8001A544};
    vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8001A544, 1'b0, 2, 1, 0, 32'h8001A544};
    vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 0, 32'h8001A544};
    vt[9]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00008001, 1'b0, 2, 1, 0, 32'h8001A544};
    vt[10] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'h8001A544};
    vt[11] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h8001A544};
    vt[12] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h8001A544};
    vt[13] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h8001A544};

    for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    init_mem = 1'b0;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("rst_ram_re", {31'h0, ram_re}, 32'd0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_wd", ram_wd, 32'h0);
    chk("rst_ram_addr", {2'b00, ram_addr}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      do_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, r, e, l, nr, nw);
      ref_op(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr[7:0], vt[i].wdata, er, ee, el);
      chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vt[i].exp_err});
      chk($sformatf("vec%0d_lat", i), l, vt[i].exp_lat);
      chk($sformatf("vec%0d_n_re", i), nr, vt[i].exp_re);
      chk($sformatf("vec%0d_n_we", i), nw, vt[i].exp_we);
      chk($sformatf("vec%0d_mem", i), mem[vt[i].addr[7:2]], vt[i].exp_word);
      $display("vec %0d: we=%b size=%0d addr=%h rdata=%h err=%b lat=%0d", i, vt[i].we,
               vt[i].size, vt[i].addr, r, e, l);
    end

    // Back-pressure: response held 5 cycles with a competing request pending
    ref_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, er, ee, el);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, er);
      chk("bp_rsp_err", {31'h0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'h0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("bp_released_req_ready", {31'h0, req_ready}, 32'd1);
    chk("bp_no_early_write", mem[5], ref_word(5));
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_competing_accepted", {31'h0, req_ready}, 32'd0);
    chk("bp_competing_write", {31'h0, ram_we}, 32'd1);
    @(posedge clk); #1;
    chk("bp_competing_rsp", {31'h0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    ref_op(1'b1, 2'd2, 1'b0, 8'h14, 32'hCAFEF00D, er, ee, el);
    chk("bp_competing_mem", mem[5], 32'hCAFEF00D);
    $display("backpressure: held response and competing store done");

    // Reset during the WRITE cycle of a byte store
    old_word = ref_word(8);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rm_read", {31'h0, ram_re}, 32'd1);
    @(posedge clk); #1;
    chk("rm_write", {31'h0, ram_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_ram_we", {31'h0, ram_we}, 32'd0);
    chk("rm_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rm_ram_addr", {2'b00, ram_addr}, 32'h0);
    chk("rm_ram_wd", ram_wd, 32'h0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rm_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rm_mem", mem[8], old_word);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, e, l, nr, nw);
    chk("rm_load", r, old_word);
    $display("reset_mid_write: reloaded %h", r);

    // Random traffic against the byte-level model
    for (int t = 0; t < 300; t++) begin
      t_we   = 1'($urandom_range(0, 1));
      t_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t_uns  = 1'($urandom_range(0, 1));
      t_addr = 8'($urandom_range(0, 255));
      t_wd   = $urandom;
      ref_op(t_we, t_size, t_uns, t_addr, t_wd, er, ee, el);
      do_req(t_we, t_size, t_uns, {24'h0, t_addr}, t_wd, r, e, l, nr, nw);
      chk($sformatf("rnd%0d_rdata", t), r, er);
      chk($sformatf("rnd%0d_err", t), {31'h0, e}, {31'h0, ee});
      chk($sformatf("rnd%0d_lat", t), l, el);
      $display("rnd %0d: we=%b size=%0d uns=%b addr=%h wd=%h rdata=%h err=%b lat=%0d",
               t, t_we, t_size, t_uns, t_addr, t_wd, r, e, l);
    end
    for (int w = 0; w < 64; w++) chk($sformatf("final_mem%0d", w), mem[w], ref_word(w));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_port.md
# data_mem_port

Load/store front end sitting directly upstream of the word-organised data RAM. It accepts one core memory request at a time and drives the RAM's `re`/`we`/`addr`/`wd` pins. Requests may be byte, halfword or word sized; sub-word stores are performed as read-modify-write because the RAM only writes whole words. Load data is returned lane-extracted and sign- or zero-extended on a valid/ready response channel.

## Interface
- (no parameters; RAM depth is owned by the RAM, this block drives the full `[31:2]` word address)

- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  core request present
- `req_ready`  out  1  block can accept a request (high only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  core accepts response
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned or illegal-size request
- `ram_re`  out  1  to RAM read enable
- `ram_rd`  in  32  from RAM; valid for `ram_addr` by the posedge ending a cycle with `ram_re`=1
- `ram_we`  out  1  to RAM write enable
- `ram_wd`  out  32  to RAM write data
- `ram_addr`  out  30  to RAM word address `[31:2]`

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `we`, `size`, `unsigned`, `addr`, `wdata`; classify:
  - error: size 11; half with addr[0]=1; word with addr[1:0]≠00. Go to RESP with `rsp_err`=1, `rsp_rdata`=0. No RAM access at all.
  - load, or store of byte/half: go to READ.
  - word store: go to WRITE with `ram_wd` = wdata.
- READ: `ram_re`=1, `ram_addr` = latched addr[31:2]. On the closing posedge sample `ram_rd`:
  - load: extract lane (byte lane = addr[1:0], half lane = addr[1], little-endian), extend per `unsigned`, register into `rsp_rdata`; go to RESP.
  - sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of `ram_rd`, keep other lanes; register into `ram_wd`; go to WRITE.
- WRITE: `ram_we`=1 for exactly one cycle; go to RESP with `rsp_rdata`=0, `rsp_err`=0.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `ram_re` is 0 outside READ and `ram_we` is 0 outside WRITE; both are never high together. `ram_rd` is ignored outside READ (RAM returns X when `re`=0).
- One request in flight; no overlap of request and response.

## Timing
- Reset (async, immediate): state IDLE; `rsp_valid`, `rsp_err`, `ram_re`, `ram_we` = 0; `rsp_rdata`, `ram_wd`, `ram_addr` = 0. `req_ready` = 1 once `rst_n` is high.
- Accept at edge 0. With `rsp_ready` tied high:
  - load: READ in cycle 1, `rsp_valid` in cycle 2; next accept at edge 3.
  - word store: WRITE in cycle 1, `rsp_valid` in cycle 2.
  - sub-word store: READ in cycle 1, WRITE in cycle 2, `rsp_valid` in cycle 3.
  - error: `rsp_valid` in cycle 1.
- `req_ready` drops on the edge after acceptance and stays low until the response handshake completes. A `req_valid` asserted during that time is not accepted, regardless of its contents.
- Reset mid-operation: all outputs return to their reset values at once. A READ is abandoned. A WRITE whose cycle has not reached its posedge does not occur, so memory is unchanged. No response is produced.
- Changes to request inputs after acceptance have no effect (everything is latched).

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> one `ram_we` pulse with `ram_addr`=0x4 and `ram_wd`=0xDEADBEEF; load `rsp_rdata`=0xDEADBEEF with `rsp_valid` 2 cycles after accept.
- Word 0x11223344 @0x10; byte store 0xA5 @0x11 -> READ then WRITE, RAM word becomes 0x1122A544; signed byte load @0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Half store 0x8001 @0x12 onto 0x1122A544 -> 0x8001A544; signed half load @0x12 -> 0xFFFF8001; unsigned -> 0x00008001; unsigned byte load @0x13 -> 0x00000080.
- Word load @0x13, half load @0x11, size 11 @0x10 -> each gives `rsp_err`=1 and `rsp_rdata`=0 one cycle after accept; `ram_re` and `ram_we` stay 0 throughout.
- Hold `rsp_ready`=0 for 5 cycles after a load -> `rsp_valid`, `rsp_rdata` and `rsp_err` stable and `req_ready`=0 throughout; a competing `req_valid` is not accepted until one cycle after `rsp_ready` rises.
- Assert `rst_n`=0 mid-cycle during the WRITE of a sub-word store -> `ram_we` falls immediately, memory word unchanged, `rsp_valid`=0; after release `req_ready`=1 and a new load returns the old value.
